// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// Sequences single-frame snapshots into ball_ram. The write gate (freeze) is
// released for exactly one active frame, then the frozen frame is handed to
// the flipdot stream generator through a start/busy handshake. A capture is
// started either by capture_req (one-shot) or, in auto mode, every FRAME_DIV
// frame ends after the previous stream has completed.
//
// Optional feature: define FRAME_CAPTURE_STATS_EN to build the
// frames_captured / req_overruns statistics counters. Without it both ports
// read as zero and the counter registers are not built.

module frame_capture_ctrl #(
  parameter int unsigned FRAME_DIV   = 4,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             ball_clock,
  input  logic             reset_n,
  input  logic             v_sync,
  input  logic             capture_req,
  input  logic             auto_mode,
  input  logic             stream_busy,
  output logic             freeze,
  output logic             stream_start,
  output logic [2:0]       state,
  output logic             ack_timeout,
  output logic [CNT_W-1:0] frames_captured,
  output logic [CNT_W-1:0] req_overruns
);

  // Handshake timer only has to count up to ACK_TIMEOUT-1.
  localparam int unsigned    TMR_W       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  // Auto mode re-arms with FRAME_DIV-1 frame ends to skip.
  localparam logic [7:0]     SKIP_RELOAD = 8'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_HOLD_REQ  = 3'd3,
    ST_HOLD_BUSY = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             v_sync_q;
  logic             vs_fall;
  logic [7:0]       skip_cnt_q, skip_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             freeze_q, freeze_d;
  logic             start_q, start_d;
  logic             ack_to_q, ack_to_d;
  logic             req_accept;
  logic             ack_expired;
  logic             hold_exit;

  // End of the active frame: v_sync was high last cycle and is low now.
  assign vs_fall    = v_sync_q & ~v_sync;
  // A request is only acted on while idle; elsewhere it is an overrun.
  assign req_accept = (state_q == ST_IDLE) & capture_req;

  // Delay v_sync by one cycle for falling-edge detection.
  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      v_sync_q <= 1'b0;
    end else begin
      v_sync_q <= v_sync;
    end
  end

  // Next-state logic: sequencing, skip counter, handshake timer, sticky timeout.
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    timer_d     = timer_q;
    ack_to_d    = ack_to_q;
    ack_expired = 1'b0;
    hold_exit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          state_d    = ST_ARM;
          skip_cnt_d = 8'd0;
          ack_to_d   = 1'b0;
        end
      end

      ST_ARM: begin
        if (vs_fall) begin
          if (skip_cnt_q == 8'd0) begin
            state_d = ST_CAPTURE;
          end else begin
            skip_cnt_d = skip_cnt_q - 8'd1;
          end
        end
      end

      ST_CAPTURE: begin
        // The window closes at the end of the frame that was just written.
        if (vs_fall) begin
          state_d = ST_HOLD_REQ;
          timer_d = '0;
        end
      end

      ST_HOLD_REQ: begin
        // Busy already high on the first cycle counts as the acknowledge.
        if (stream_busy) begin
          state_d = ST_HOLD_BUSY;
        end else if (timer_q == TMR_LAST) begin
          ack_expired = 1'b1;
          hold_exit   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_HOLD_BUSY: begin
        if (!stream_busy) begin
          hold_exit = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ack_expired) begin
      ack_to_d = 1'b1;
    end

    // Leaving the hold: auto mode is sampled only on this cycle.
    if (hold_exit) begin
      if (auto_mode) begin
        state_d    = ST_ARM;
        skip_cnt_d = SKIP_RELOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Registered outputs derived from the upcoming state so they line up with it.
  always_comb begin
    freeze_d = (state_d != ST_CAPTURE);
    start_d  = (state_d == ST_HOLD_REQ) && (state_q != ST_HOLD_REQ);
  end

  // State, counters and registered outputs; freeze closes at once on reset.
  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      skip_cnt_q <= 8'd0;
      timer_q    <= '0;
      freeze_q   <= 1'b1;
      start_q    <= 1'b0;
      ack_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      timer_q    <= timer_d;
      freeze_q   <= freeze_d;
      start_q    <= start_d;
      ack_to_q   <= ack_to_d;
    end
  end

  assign freeze       = freeze_q;
  assign stream_start = start_q;
  assign state        = state_q;
  assign ack_timeout  = ack_to_q;

`ifdef FRAME_CAPTURE_STATS_EN
  logic             req_overrun;
  logic [CNT_W-1:0] frames_q;
  logic [CNT_W-1:0] overruns_q;

  assign req_overrun = (state_q != ST_IDLE) & capture_req;

  // Completed captures (wrapping) and ignored requests (saturating).
  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      frames_q   <= '0;
      overruns_q <= '0;
    end else begin
      if (hold_exit) begin
        frames_q <= frames_q + CNT_W'(1);
      end
      if (req_overrun && (overruns_q != {CNT_W{1'b1}})) begin
        overruns_q <= overruns_q + CNT_W'(1);
      end
    end
  end

  assign frames_captured = frames_q;
  assign req_overruns    = overruns_q;
`else
  assign frames_captured = '0;
  assign req_overruns    = '0;
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Testbench for frame_capture_ctrl. The whole v_sync waveform is planned up
// front; each capture is described at transaction level ("Nth frame end after
// arming", "busy rises d cycles after start") and turned into a list of
// expected output events. A monitor compares observed output changes against
// that list in order.

module tb_frame_capture_ctrl;

  localparam int FRAME_DIV   = 4;
  localparam int ACK_TIMEOUT = 1024;
  localparam int CNT_W       = 16;
  localparam int NCYC        = 30000;

  localparam int K_STATE  = 0;
  localparam int K_FREEZE = 1;
  localparam int K_START  = 2;
  localparam int K_ACK    = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
    int fr;
  } evt_t;

  evt_t exp_q[$];

  logic             ball_clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             v_sync = 1'b0;
  logic             capture_req = 1'b0;
  logic             auto_mode = 1'b0;
  logic             stream_busy = 1'b0;
  logic             freeze;
  logic             stream_start;
  logic [2:0]       state;
  logic             ack_timeout;
  logic [CNT_W-1:0] frames_captured;
  logic [CNT_W-1:0] req_overruns;

  bit vs_arr[NCYC];
  bit req_arr[NCYC];
  bit busy_arr[NCYC];
  bit auto_arr[NCYC];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int frames_exp = 0;
  int ovr_exp = 0;
  bit ack_exp = 1'b0;

  frame_capture_ctrl #(
    .FRAME_DIV  (FRAME_DIV),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .ball_clock     (ball_clock),
    .reset_n        (reset_n),
    .v_sync         (v_sync),
    .capture_req    (capture_req),
    .auto_mode      (auto_mode),
    .stream_busy    (stream_busy),
    .freeze         (freeze),
    .stream_start   (stream_start),
    .state          (state),
    .ack_timeout    (ack_timeout),
    .frames_captured(frames_captured),
    .req_overruns   (req_overruns)
  );

  always #5 ball_clock = ~ball_clock;

  // Counter values as seen on the ports for the current build.
  function automatic int exp_cnt(int v);
`ifdef FRAME_CAPTURE_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic string kname(int k);
    case (k)
      K_STATE:  return "state";
      K_FREEZE: return "freeze";
      K_START:  return "stream_start";
      default:  return "ack_timeout";
    endcase
  endfunction

  function automatic bit is_fall(int t);
    return (t >= 1) && (t < NCYC) && vs_arr[t-1] && !vs_arr[t];
  endfunction

  // Cycle of the n-th frame end at or after cycle 'from'.
  function automatic int nth_fall(int from, int n);
    int cnt = 0;
    for (int t = from; t < NCYC; t++) begin
      if (is_fall(t)) begin
        cnt++;
        if (cnt == n) return t;
      end
    end
    return NCYC + 1000;
  endfunction

  function automatic void set_busy(int i, bit v);
    if (i >= 0 && i < NCYC) busy_arr[i] = v;
  endfunction

  function automatic void set_req(int i);
    if (i >= 0 && i < NCYC) req_arr[i] = 1'b1;
  endfunction

  function automatic void set_auto(int i, bit v);
    if (i >= 0 && i < NCYC) auto_arr[i] = v;
  endfunction

  function automatic void push(int k, int c, int v, int f);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    e.fr   = f;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, got, cyc);
    end
  endtask

  // One capture starting with the controller armed at cycle a.
  // bdel < 0: busy never answers. Returns first frame end t1 and hold exit e.
  task automatic plan_from_arm(input int a, input int skip, input int bdel, input int blen,
                               input bit auto_exit, output int t1, output int e);
    int t2, s, h;
    t1 = nth_fall(a, skip + 1);
    t2 = nth_fall(t1 + 1, 1);
    push(K_STATE, t1 + 1, 2, -1);
    push(K_FREEZE, t1 + 1, 0, -1);
    s = t2 + 1;
    push(K_STATE, s, 3, -1);
    push(K_FREEZE, s, 1, -1);
    push(K_START, s, 1, -1);
    if (bdel >= 0) begin
      h = s + bdel;
      for (int i = s; i < h; i++) set_busy(i, 1'b0);
      if (bdel == 0) set_busy(s - 1, 1'b1);
      for (int i = 0; i < blen; i++) set_busy(h + i, 1'b1);
      e = h + blen;
      set_busy(e, 1'b0);
      push(K_STATE, h + 1, 4, -1);
    end else begin
      e = s + ACK_TIMEOUT - 1;
      for (int i = s; i <= e; i++) set_busy(i, 1'b0);
    end
    set_auto(e, auto_exit);
    frames_exp++;
    push(K_STATE, e + 1, auto_exit ? 1 : 0, frames_exp);
    if (bdel < 0 && !ack_exp) begin
      push(K_ACK, e + 1, 1, -1);
      ack_exp = 1'b1;
    end
  endtask

  // Capture requested in IDLE at cycle r, request held for len cycles.
  task automatic plan_from_idle(input int r, input int len, input int bdel, input int blen,
                                input bit auto_exit, output int t1, output int e);
    for (int i = 0; i < len; i++) set_req(r + i);
    push(K_STATE, r + 1, 1, -1);
    if (ack_exp) begin
      push(K_ACK, r + 1, 0, -1);
      ack_exp = 1'b0;
    end
    ovr_exp += len - 1;
    plan_from_arm(r + 1, 0, bdel, blen, auto_exit, t1, e);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge ball_clock);
  endtask

  task automatic observe(int k, int v);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, required no change",
               kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL event: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end else begin
        $display("ok   event %s=%0d at cycle %0d", kname(k), v, cyc);
      end
      if (e.fr >= 0) chk("frames_captured", int'(frames_captured), exp_cnt(e.fr));
    end
  endtask

  // Input driver: replays the planned waveforms, one entry per cycle.
  initial begin
    forever begin
      @(posedge ball_clock);
      cyc = cyc + 1;
      #1;
      if (cyc >= NCYC - 2) begin
        errors++;
        $display("FAIL watchdog: reached cycle %0d, required finish before %0d", cyc, NCYC - 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "cycle budget exhausted");
      end
      v_sync      = vs_arr[cyc];
      capture_req = req_arr[cyc];
      stream_busy = busy_arr[cyc];
      auto_mode   = auto_arr[cyc];
    end
  end

  // Monitor: every output change (and each stream_start cycle) is one event.
  logic [2:0] p_state;
  logic       p_freeze;
  logic       p_ack;
  initial begin
    p_state  = 3'd0;
    p_freeze = 1'b1;
    p_ack    = 1'b0;
    forever begin
      @(negedge ball_clock);
      if (mon_en) begin
        if (state !== p_state)      observe(K_STATE, int'(state));
        if (freeze !== p_freeze)    observe(K_FREEZE, int'(freeze));
        if (stream_start === 1'b1)  observe(K_START, 1);
        if (ack_timeout !== p_ack)  observe(K_ACK, int'(ack_timeout));
      end
      p_state  = state;
      p_freeze = freeze;
      p_ack    = ack_timeout;
    end
  end

  // Main sequence.
  initial begin
    int t, t1, e, r, len, nchain, bdel, blen, rst_t1;

    // Frame plan: random blanking and active lengths from cycle 10 on.
    t = 10;
    while (t < NCYC) begin
      int nb = $urandom_range(5, 20);
      int na = $urandom_range(20, 60);
      for (int j = 0; j < nb && t < NCYC; j++) begin vs_arr[t] = 1'b0; t++; end
      for (int j = 0; j < na && t < NCYC; j++) begin vs_arr[t] = 1'b1; t++; end
    end
    // auto_mode and stream_busy toggle randomly where they must be ignored.
    for (int i = 10; i < NCYC; i++) begin
      auto_arr[i] = 1'($urandom_range(0, 1));
      busy_arr[i] = ($urandom_range(0, 3) == 0);
    end

    reset_n = 1'b0;
    wait_until(5);
    @(posedge ball_clock);
    #1 reset_n = 1'b1;
    @(negedge ball_clock);
    chk("reset_state", int'(state), 0);
    chk("reset_freeze", int'(freeze), 1);
    chk("reset_stream_start", int'(stream_start), 0);
    chk("reset_ack_timeout", int'(ack_timeout), 0);
    chk("reset_frames_captured", int'(frames_captured), 0);
    chk("reset_req_overruns", int'(req_overruns), 0);
    mon_en = 1'b1;

    // Manual capture, busy answers after 5 cycles for 100 cycles.
    r = cyc + 3;
    plan_from_idle(r, 1, 5, 100, 1'b0, t1, e);
    wait_until(e + 5);

    // Busy never answers: handshake timeout.
    r = cyc + 3;
    plan_from_idle(r, 1, -1, 0, 1'b0, t1, e);
    wait_until(e + 5);
    chk("timeout_ack_timeout", int'(ack_timeout), 1);
    chk("timeout_state", int'(state), 0);

    // Next request clears the timeout; 10-cycle request during CAPTURE.
    r = cyc + 3;
    plan_from_idle(r, 1, 7, 30, 1'b0, t1, e);
    for (int i = 0; i < 10; i++) set_req(t1 + 3 + i);
    ovr_exp += 10;
    wait_until(e + 5);
    chk("overrun_req_overruns", int'(req_overruns), exp_cnt(ovr_exp));

    // Auto mode: three captures, each re-arm skips FRAME_DIV-1 frame ends.
    r = cyc + 3;
    plan_from_idle(r, 1, 3, 20, 1'b1, t1, e);
    plan_from_arm(e + 1, FRAME_DIV - 1, 2, 15, 1'b1, t1, e);
    plan_from_arm(e + 1, FRAME_DIV - 1, 0, 10, 1'b0, t1, e);
    wait_until(e + 5);

    // Randomized captures and auto chains.
    for (int it = 0; it < 8; it++) begin
      r      = cyc + 3 + $urandom_range(0, 20);
      len    = $urandom_range(1, 3);
      nchain = $urandom_range(1, 3);
      for (int k = 0; k < nchain; k++) begin
        bdel = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 12);
        blen = $urandom_range(1, 40);
        if (k == 0) plan_from_idle(r, len, bdel, blen, (k < nchain - 1), t1, e);
        else        plan_from_arm(e + 1, FRAME_DIV - 1, bdel, blen, (k < nchain - 1), t1, e);
      end
      wait_until(e + 5);
      chk("random_req_overruns", int'(req_overruns), exp_cnt(ovr_exp));
    end

    // Reset in the middle of CAPTURE abandons the frame.
    r = cyc + 3;
    plan_from_idle(r, 1, -1, 0, 1'b0, t1, e);
    rst_t1 = t1;
    wait_until(rst_t1 + 5);
    chk("midcap_freeze_open", int'(freeze), 0);
    mon_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_freeze", int'(freeze), 1);
    chk("async_reset_state", int'(state), 0);
    exp_q.delete();
    frames_exp = 0;
    ovr_exp    = 0;
    ack_exp    = 1'b0;
    repeat (2) @(posedge ball_clock);
    #1 reset_n = 1'b1;
    @(negedge ball_clock);
    mon_en = 1'b1;
    wait_until(rst_t1 + 200);
    chk("post_reset_state", int'(state), 0);
    chk("post_reset_freeze", int'(freeze), 1);
    chk("post_reset_frames_captured", int'(frames_captured), exp_cnt(frames_exp));
    chk("post_reset_req_overruns", int'(req_overruns), exp_cnt(ovr_exp));

    @(negedge ball_clock);
    chk("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences single-frame snapshots of the thresholded white-pixel image into ball_ram.
- Opens the RAM write window (freeze low) for exactly one complete active frame, then re-freezes.
- Hands the frozen frame to the flipdot serial stream generator via a start/busy handshake.
- Supports manual (one-shot) and auto (every FRAME_DIV frames) capture; replaces the raw freeze switch.

Parameters:
- FRAME_DIV, 4, frames per auto-mode capture period (ARM skips FRAME_DIV-1 frame ends); legal range 1..255.
- ACK_TIMEOUT, 1024, ball_clock cycles allowed for stream_busy to rise after stream_start.
- CNT_W, 16, width of statistics counters.

Ports:
- ball_clock  in  1  pixel clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- v_sync  in  1  high during active rows; falling edge = end of active frame.
- capture_req  in  1  level or pulse; request one capture; sampled each cycle.
- auto_mode  in  1  1 = re-arm automatically after each stream completes.
- stream_busy  in  1  high while serial_stream_gen is transmitting a frame.
- freeze  out  1  to ball_ram write gate; 0 only during CAPTURE.
- stream_start  out  1  one-cycle pulse requesting a flipdot transmission.
- state  out  3  current FSM state, for debug header.
- ack_timeout  out  1  sticky; set on handshake timeout, cleared on next capture_req accepted in IDLE.
- frames_captured  out  CNT_W  completed captures (optional feature).
- req_overruns  out  CNT_W  capture_req seen while not IDLE (optional feature).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, freeze=1, stream_start=0, ack_timeout=0, counters=0, v_sync_d=0, skip_cnt=0, timer=0.
- v_sync registered once (v_sync_d). vs_fall = v_sync_d & ~v_sync, evaluated combinationally in the same cycle.
- State encoding: IDLE=0, ARM=1, CAPTURE=2, HOLD_REQ=3, HOLD_BUSY=4. All outputs are registered.
- IDLE:
  - capture_req=1 → ARM, skip_cnt=0, clear ack_timeout.
  - Otherwise stay.
- ARM:
  - On vs_fall with skip_cnt=0 → CAPTURE.
  - On vs_fall with skip_cnt>0 → decrement skip_cnt, stay.
- CAPTURE:
  - freeze=0 starting the cycle after the entering vs_fall; the window therefore spans one full active frame, starting in blanking.
  - On the next vs_fall → HOLD_REQ, freeze=1 the following cycle.
- HOLD_REQ:
  - stream_start=1 for exactly the first cycle in this state; timer counts from 0.
  - stream_busy=1 → HOLD_BUSY.
  - timer reaches ACK_TIMEOUT-1 with no busy → set ack_timeout, take the HOLD exit.
- HOLD_BUSY: on stream_busy=0, take the HOLD exit.
- HOLD exit:
  - Increment frames_captured.
  - auto_mode=1 (sampled at this cycle only) → ARM with skip_cnt=FRAME_DIV-1.
  - Otherwise → IDLE.
- vs_fall outside ARM/CAPTURE is ignored.
- stream_busy already 1 on entry to HOLD_REQ counts as ack on that cycle; stream_start still pulses.
- capture_req while state≠IDLE: ignored; req_overruns increments once per cycle asserted; saturates at all-ones.
- frames_captured wraps modulo 2^CNT_W.
- Reset mid-CAPTURE: freeze returns to 1 immediately (async); the partially written frame is abandoned.
- Only the state/timer/skip_cnt counters need widths: timer is clog2(ACK_TIMEOUT) bits, skip_cnt is 8 bits.

Optional Feature:
- Macro: FRAME_CAPTURE_STATS_EN.
- Defined: frames_captured and req_overruns are live counters as above.
- Undefined: both ports are tied to 0, their counter registers are not built, and the remaining behaviour is identical.

Test Plan:
- Reset then capture_req pulse in IDLE; 3 frames of v_sync → freeze=0 from cycle after first vs_fall through cycle of second vs_fall; freeze=1 otherwise.
- After capture, stream_busy rises 5 cycles after stream_start and is high 100 cycles → exactly one stream_start pulse; state 3→4→0; frames_captured=1.
- auto_mode=1, FRAME_DIV=4, busy responds normally → captures on every 4th frame end (skips 3 vs_fall after each HOLD exit).
- stream_busy held 0 → ack_timeout=1 after 1024 cycles in HOLD_REQ; state→IDLE; next capture_req clears it.
- capture_req held 10 cycles during CAPTURE → req_overruns=10 with macro, 0 without; capture unaffected.
- reset_n pulsed low mid-CAPTURE → freeze=1 asynchronously; state=0; no stream_start afterwards.
